// File: rtl/id_pkg.sv
// Shared constants and types for the $DFA0-$DFFF identification window.
// Address map and toggle patterns must match the ID responder side.
package id_pkg;

    localparam logic [15:0] TOG_ADDR  = 16'hDFFF;
    localparam logic [15:0] IDC_ADDR  = 16'hDFFE;
    localparam logic [15:0] VERH_ADDR = 16'hDFFD;
    localparam logic [15:0] VERL_ADDR = 16'hDFFC;
    localparam logic [15:0] STR_ADDR  = 16'hDFA0;

    localparam logic [7:0] EXPECT_ID = 8'h43;
    localparam logic [7:0] TOG_PAT_A = 8'h55;
    localparam logic [7:0] TOG_PAT_B = 8'hAA;

    localparam int STR_MAX_DEF = 20;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        ERR_OK       = 3'd0,
        ERR_TIMEOUT  = 3'd1,
        ERR_TOGGLE   = 3'd2,
        ERR_ID       = 3'd3,
        ERR_OVERFLOW = 3'd4
    } err_code_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOG1,
        ST_TOG2,
        ST_IDC,
        ST_VERH,
        ST_VERL,
        ST_STR,
        ST_FIN
    } probe_state_t;

    function automatic logic is_toggle_pat(input logic [7:0] b);
        return (b == TOG_PAT_A) || (b == TOG_PAT_B);
    endfunction

endpackage

// File: rtl/bus_rd_master.sv
// Single-read bus master: holds req/addr until ack or until the per-read
// timeout expires. rdone/rtimeout/rdata are combinational in the ack cycle.
module bus_rd_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_go,
    input  logic [15:0] i_addr,
    output logic        o_bus_req,
    output logic [15:0] o_bus_addr,
    input  logic        i_bus_ack,
    input  logic [7:0]  i_bus_din,
    output logic        o_rdone,
    output logic        o_rtimeout,
    output logic [7:0]  o_rdata
);

    logic        r_req;
    logic [15:0] r_addr;
    logic [7:0]  r_cnt;
    logic        w_last;

    // r_cnt counts req-high cycles from 0, so req stays up exactly TIMEOUT cycles.
    assign w_last     = (r_cnt == 8'(TIMEOUT - 1));
    assign o_rdone    = r_req & i_bus_ack;
    assign o_rtimeout = r_req & ~i_bus_ack & w_last;
    assign o_rdata    = i_bus_din;
    assign o_bus_req  = r_req;
    assign o_bus_addr = r_addr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_req  <= 1'b0;
            r_addr <= 16'h0000;
            r_cnt  <= 8'h00;
        end else if (r_req) begin
            if (i_bus_ack || w_last) begin
                r_req <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 8'h01;
            end
        end else if (i_go) begin
            r_req  <= 1'b1;
            r_addr <= i_addr;
            r_cnt  <= 8'h00;
        end
    end

endmodule

// File: rtl/id_probe.sv
// Identification-window probe: walks toggle, ID, version and copyright string
// reads through bus_rd_master and reports detected/err_code to the host.
module id_probe
    import id_pkg::*;
#(
    parameter int STR_MAX = STR_MAX_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_detected,
    output logic [2:0]   o_err_code,
    output logic [15:0]  o_version,
    output logic [4:0]   o_str_len,
    input  logic [4:0]   i_str_rd_idx,
    output logic [7:0]   o_str_rd_data,
    output logic         o_bus_req,
    output logic [15:0]  o_bus_addr,
    input  logic         i_bus_ack,
    input  logic [7:0]   i_bus_din,
    output probe_state_t o_state
);

    probe_state_t r_state;
    probe_state_t w_next;
    logic         r_pending;
    logic [7:0]   r_t1;
    logic         r_detected;
    err_code_t    r_err;
    logic [15:0]  r_version;
    logic [4:0]   r_str_len;
    logic [4:0]   r_n;
    logic [7:0]   r_buf [STR_MAX];

    logic         w_go;
    logic [15:0]  w_rd_addr;
    logic         w_rdone;
    logic         w_rtimeout;
    logic [7:0]   w_rdata;
    logic         w_str_last;

    bus_rd_master #(.TIMEOUT(TIMEOUT)) u_rd (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_go       (w_go),
        .i_addr     (w_rd_addr),
        .o_bus_req  (o_bus_req),
        .o_bus_addr (o_bus_addr),
        .i_bus_ack  (i_bus_ack),
        .i_bus_din  (i_bus_din),
        .o_rdone    (w_rdone),
        .o_rtimeout (w_rtimeout),
        .o_rdata    (w_rdata)
    );

    assign w_str_last = (r_n == 5'(STR_MAX - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Each read state issues one go, then waits for rdone or rtimeout; the
    // state change on completion guarantees an idle bus cycle before the next go.
    always_comb begin
        w_next    = r_state;
        w_go      = 1'b0;
        w_rd_addr = 16'h0000;
        case (r_state)
            ST_IDLE: if (i_start) w_next = ST_TOG1;
            ST_FIN:  w_next = ST_IDLE;
            default: begin
                w_go = ~r_pending;
                case (r_state)
                    ST_TOG1, ST_TOG2: w_rd_addr = TOG_ADDR;
                    ST_IDC:           w_rd_addr = IDC_ADDR;
                    ST_VERH:          w_rd_addr = VERH_ADDR;
                    ST_VERL:          w_rd_addr = VERL_ADDR;
                    default:          w_rd_addr = STR_ADDR + {11'b0, r_n};
                endcase
                if (w_rtimeout) begin
                    w_next = ST_FIN;
                end else if (w_rdone) begin
                    case (r_state)
                        ST_TOG1: w_next = is_toggle_pat(w_rdata) ? ST_TOG2 : ST_FIN;
                        ST_TOG2: w_next = (w_rdata == ~r_t1) ? ST_IDC : ST_FIN;
                        ST_IDC:  w_next = (w_rdata == EXPECT_ID) ? ST_VERH : ST_FIN;
                        ST_VERH: w_next = ST_VERL;
                        ST_VERL: w_next = ST_STR;
                        default: if (w_rdata == 8'h00 || w_str_last) w_next = ST_FIN;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pending  <= 1'b0;
            r_t1       <= 8'h00;
            r_detected <= 1'b0;
            r_err      <= ERR_OK;
            r_version  <= 16'h0000;
            r_str_len  <= 5'd0;
            r_n        <= 5'd0;
        end else begin
            if (w_go)                        r_pending <= 1'b1;
            else if (w_rdone || w_rtimeout)  r_pending <= 1'b0;

            if (r_state == ST_IDLE && i_start) begin
                r_detected <= 1'b0;
                r_err      <= ERR_OK;
                r_version  <= 16'h0000;
                r_str_len  <= 5'd0;
                r_n        <= 5'd0;
            end

            if (w_rtimeout) begin
                r_err <= ERR_TIMEOUT;
            end else if (w_rdone) begin
                case (r_state)
                    ST_TOG1: begin
                        if (is_toggle_pat(w_rdata)) r_t1  <= w_rdata;
                        else                        r_err <= ERR_TOGGLE;
                    end
                    ST_TOG2: if (w_rdata != ~r_t1)     r_err <= ERR_TOGGLE;
                    ST_IDC:  if (w_rdata != EXPECT_ID) r_err <= ERR_ID;
                    ST_VERH: r_version[15:8] <= w_rdata;
                    ST_VERL: begin
                        r_version[7:0] <= w_rdata;
                        r_n            <= 5'd0;
                    end
                    ST_STR: begin
                        if (w_rdata == 8'h00) begin
                            r_str_len  <= r_n;
                            r_detected <= 1'b1;
                        end else if (w_str_last) begin
                            r_err     <= ERR_OVERFLOW;
                            r_str_len <= 5'(STR_MAX);
                        end else begin
                            r_n <= r_n + 5'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Buffer contents are qualified by r_str_len, so they need no reset.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && r_state == ST_STR && w_rdone && w_rdata != 8'h00)
            r_buf[r_n] <= w_rdata;
    end

    assign o_str_rd_data = (i_str_rd_idx < r_str_len) ? r_buf[i_str_rd_idx] : 8'hFF;
    assign o_busy        = (r_state != ST_IDLE) && (r_state != ST_FIN);
    assign o_done        = (r_state == ST_FIN);
    assign o_detected    = r_detected;
    assign o_err_code    = r_err;
    assign o_version     = r_version;
    assign o_str_len     = r_str_len;
    assign o_state       = r_state;

endmodule

// File: tb/tb_id_probe.sv
// Directed bench for id_probe with a behavioural ID-window responder.
module tb_id_probe;
  import id_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         busy;
  logic         done;
  logic         detected;
  logic [2:0]   err_code;
  logic [15:0]  version;
  logic [4:0]   str_len;
  logic [4:0]   str_rd_idx;
  logic [7:0]   str_rd_data;
  logic         bus_req;
  logic [15:0]  bus_addr;
  logic         bus_ack;
  logic [7:0]   bus_din;
  probe_state_t dbg_state;

  int n_vec = 0;
  int n_mis = 0;

  // responder controls: 0 compliant, 1 open bus, 2 bad ID, 3 no NUL
  int mode      = 0;
  int fixed_lat = 1;
  bit rand_lat  = 0;
  bit no_ack    = 0;
  int cur_lat   = 1;
  int wcnt      = 0;
  bit tog_phase = 0;
  int n_reads   = 0;
  string cpy    = "SuperCPU FPGA v1.0";

  // monitor counters
  int done_cnt   = 0;
  int req_cycles = 0;
  int hs_viol    = 0;
  logic prev_ack_hit = 1'b0;

  id_probe dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .o_busy       (busy),
    .o_done       (done),
    .o_detected   (detected),
    .o_err_code   (err_code),
    .o_version    (version),
    .o_str_len    (str_len),
    .i_str_rd_idx (str_rd_idx),
    .o_str_rd_data(str_rd_data),
    .o_bus_req    (bus_req),
    .o_bus_addr   (bus_addr),
    .i_bus_ack    (bus_ack),
    .i_bus_din    (bus_din),
    .o_state      (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] str_byte(input int idx);
    if (mode == 3) return 8'h41 + 8'(idx);
    if (idx < cpy.len()) return cpy[idx];
    if (idx == cpy.len()) return 8'h0D;
    return 8'h00;
  endfunction

  // Responder: acks after cur_lat extra req cycles, drops ack the next cycle.
  always @(posedge clk) begin
    #1;
    if (bus_ack) begin
      bus_ack = 1'b0;
      wcnt = 0;
    end else if (!bus_req) begin
      wcnt = 0;
    end else if (!no_ack) begin
      if (wcnt >= cur_lat) begin
        bus_ack = 1'b1;
        n_reads++;
        if (mode == 1) bus_din = 8'hFF;
        else if (bus_addr == TOG_ADDR) begin
          bus_din = tog_phase ? 8'hAA : 8'h55;
          tog_phase = ~tog_phase;
        end
        else if (bus_addr == IDC_ADDR) bus_din = (mode == 2) ? 8'h41 : 8'h43;
        else if (bus_addr == VERH_ADDR) bus_din = 8'h01;
        else if (bus_addr == VERL_ADDR) bus_din = 8'h00;
        else bus_din = str_byte(int'(bus_addr - STR_ADDR));
        wcnt = 0;
        cur_lat = rand_lat ? int'($urandom_range(0, 10)) : fixed_lat;
      end else begin
        wcnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (bus_req) req_cycles++;
    if (prev_ack_hit && bus_req) hs_viol++;
    prev_ack_hit = bus_req && bus_ack;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic prep(input int m, input int lat, input bit rl, input bit na);
    mode = m; fixed_lat = lat; rand_lat = rl; no_ack = na;
    cur_lat = rl ? int'($urandom_range(0, 10)) : lat;
    tog_phase = 0; n_reads = 0; req_cycles = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit got = 0;
    for (int c = 0; c < 20000; c++) begin
      if (done) begin got = 1; break; end
      @(negedge clk);
    end
    check(tag, 32'(got), 32'd1);
  endtask

  task automatic read_buf(input logic [4:0] idx, output logic [7:0] d);
    str_rd_idx = idx; #1; d = str_rd_data;
  endtask

  initial begin
    logic [7:0] d;
    int dc0;
    bit hit;
    rst_n = 1'b0; start = 1'b0; str_rd_idx = 5'd0; bus_ack = 1'b0; bus_din = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_det", 32'(detected), 32'd0);
    check("rst_err", 32'(err_code), 32'd0);
    check("rst_ver", 32'(version), 32'd0);
    check("rst_len", 32'(str_len), 32'd0);
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_addr", 32'(bus_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // compliant responder, latency 1
    prep(0, 1, 0, 0);
    dc0 = done_cnt;
    pulse_start();
    check("c_busy", 32'(busy), 32'd1);
    wait_done("c_done");
    check("c_det", 32'(detected), 32'd1);
    check("c_err", 32'(err_code), 32'd0);
    check("c_ver", 32'(version), 32'h0100);
    check("c_len", 32'(str_len), 32'd19);
    check("c_reads", 32'(n_reads), 32'd25);
    // start in the FIN cycle must be ignored
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("c_fin_start_busy", 32'(busy), 32'd0);
    check("c_fin_start_done", 32'(done), 32'd0);
    check("c_done_cnt", 32'(done_cnt - dc0), 32'd1);
    read_buf(5'd0, d);  check("c_buf0", 32'(d), 32'h53);
    read_buf(5'd18, d); check("c_buf18", 32'(d), 32'h0D);
    read_buf(5'd19, d); check("c_buf19", 32'(d), 32'hFF);
    check("c_hold_det", 32'(detected), 32'd1);

    // open bus
    prep(1, 1, 0, 0);
    pulse_start();
    wait_done("o_done");
    check("o_err", 32'(err_code), 32'd2);
    check("o_det", 32'(detected), 32'd0);
    check("o_reads", 32'(n_reads), 32'd1);
    check("o_ver", 32'(version), 32'd0);
    read_buf(5'd0, d); check("o_buf0", 32'(d), 32'hFF);

    // bad ID character
    prep(2, 0, 0, 0);
    pulse_start();
    wait_done("i_done");
    check("i_err", 32'(err_code), 32'd3);
    check("i_ver", 32'(version), 32'd0);
    check("i_reads", 32'(n_reads), 32'd3);

    // no ack ever
    prep(0, 1, 0, 1);
    pulse_start();
    wait_done("t_done");
    check("t_req_cycles", 32'(req_cycles), 32'd255);
    check("t_err", 32'(err_code), 32'd1);
    check("t_det", 32'(detected), 32'd0);
    @(negedge clk);
    check("t_req_low", 32'(bus_req), 32'd0);

    // missing NUL, random latency
    prep(3, 0, 1, 0);
    pulse_start();
    wait_done("n_done");
    check("n_err", 32'(err_code), 32'd4);
    check("n_len", 32'(str_len), 32'd20);
    check("n_det", 32'(detected), 32'd0);
    check("n_reads", 32'(n_reads), 32'd25);
    check("n_ver", 32'(version), 32'h0100);
    read_buf(5'd19, d); check("n_buf19", 32'(d), 32'h54);
    read_buf(5'd20, d); check("n_buf20", 32'(d), 32'hFF);

    // start during busy is ignored
    prep(0, 2, 0, 0);
    dc0 = done_cnt;
    pulse_start();
    repeat (10) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done("b_done");
    check("b_reads", 32'(n_reads), 32'd25);
    check("b_det", 32'(detected), 32'd1);
    @(negedge clk);
    check("b_done_cnt", 32'(done_cnt - dc0), 32'd1);

    // reset in the middle of the string read
    prep(0, 2, 0, 0);
    pulse_start();
    dc0 = done_cnt;
    hit = 0;
    for (int c = 0; c < 2000; c++) begin
      if (bus_req && bus_addr == 16'hDFA5) begin hit = 1; break; end
      @(negedge clk);
    end
    check("r_reached_str", 32'(hit), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("r_req", 32'(bus_req), 32'd0);
    check("r_busy", 32'(busy), 32'd0);
    check("r_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("r_no_done", 32'(done_cnt - dc0), 32'd0);
    check("r_det", 32'(detected), 32'd0);
    check("r_len", 32'(str_len), 32'd0);

    check("hs_next_cycle_drop", 32'(hs_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
